// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// Latency: n/a (wires only); master = sequencer, slave = datapath/memory side.
// Backpressure: mem_ready from the memory stalls the sequencer; Illegal exists only with CTRL_ILLEGAL_TRAP_EN.
interface multicycle_control_if #(
  parameter int ALUOP_W = 6
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               InstrDone;
  logic               MemFault;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic               Illegal;
`endif

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, InstrDone, MemFault
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUOp, InstrDone, MemFault
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer (FETCH/DECODE/EXECUTE/MEM/WB); optional illegal-opcode trap via CTRL_ILLEGAL_TRAP_EN.
// Latency: LW 5, SW/R-type/XORI 4, BNE/J/JAL/JR/NOOP 3 cycles at zero memory wait; outputs are a Moore decode of state.
// Backpressure: FETCH/MEMRD/MEMWR hold their request until mem_ready; WAIT_MAX waits pulse MemFault and retry.
module multicycle_control #(
  parameter int ALUOP_W  = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(6'b100000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6'b100010);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(6'b100110);
  localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(6'b101100);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_NOP  = 6'b000000;

  localparam int            CW      = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB,
    IEX, IWB, BRANCH, JUMP, JALS, JRS, NOPS, HALT
  } state_t;

  state_t        state, state_nxt;
  logic          started;   // low from reset until the first posedge after release
  logic [CW-1:0] cnt;
  logic [5:0]    fn_q;      // funct captured in DECODE, drives ALUOp for R-type
  logic          lw_q;      // MEMADR branches to MEMRD (LW) or MEMWR (SW)
  logic          waiting;
  logic          fault;

  assign waiting = started && (state == FETCH || state == MEMRD || state == MEMWR);
  // Completion beats the limit: fault only when this cycle is itself a wait.
  assign fault   = waiting && !bus.mem_ready && (cnt == CNT_MAX);

  // State register; reset forces FETCH and masks all outputs for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
    end
  end

  // Memory wait counter and DECODE-time instruction fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      fn_q <= '0;
      lw_q <= 1'b0;
    end else begin
      if (waiting && !bus.mem_ready && !fault) cnt <= cnt + 1'b1;
      else                                     cnt <= '0;
      if (started && state == DECODE) begin
        fn_q <= bus.funct;
        lw_q <= (bus.opcode == OP_LW);
      end
    end
  end

  // Next-state and Moore output decode; defaults are the idle/reset values.
  always_comb begin
    state_nxt       = state;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 2'd0;
    bus.MemtoReg    = 2'd0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'd0;
    bus.PCSource    = 2'd0;
    bus.ALUOp       = ALU_NOP;
    bus.InstrDone   = 1'b0;
    bus.MemFault    = fault;
`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.Illegal     = 1'b0;
`endif
    if (started) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'd1;
          bus.ALUOp   = ALU_ADD;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            state_nxt   = DECODE;
          end
        end
        DECODE: begin
          bus.ALUSrcB = 2'd2;
          bus.ALUOp   = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt   = HALT;
`else
          state_nxt   = NOPS;
`endif
          case (bus.opcode)
            OP_LW, OP_SW: state_nxt = MEMADR;
            OP_XORI:      state_nxt = IEX;
            OP_BNE:       state_nxt = BRANCH;
            OP_J:         state_nxt = JUMP;
            OP_JAL:       state_nxt = JALS;
            OP_R: begin
              case (bus.funct)
                FN_ADD, FN_SUB, FN_SLT: state_nxt = REX;
                FN_JR:                  state_nxt = JRS;
                FN_NOP:                 state_nxt = NOPS;
                default:                ;
              endcase
            end
            default: ;
          endcase
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'd2;
          bus.ALUOp   = ALU_ADD;
          state_nxt   = lw_q ? MEMRD : MEMWR;
        end
        MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
          if (bus.mem_ready) state_nxt = MEMWB;
        end
        MEMWB: begin
          bus.MemtoReg  = 2'd1;
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        MEMWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
          if (bus.mem_ready) begin
            bus.InstrDone = 1'b1;
            state_nxt     = FETCH;
          end
        end
        REX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_W'(fn_q);
          state_nxt   = RWB;
        end
        RWB: begin
          bus.RegDst    = 2'd1;
          bus.RegWrite  = 1'b1;
          bus.ALUOp     = ALUOP_W'(fn_q);
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        IEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'd3;
          bus.ALUOp   = ALU_XOR;
          state_nxt   = IWB;
        end
        IWB: begin
          bus.RegWrite  = 1'b1;
          bus.ALUOp     = ALU_XOR;
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'd1;
          bus.InstrDone   = 1'b1;
          state_nxt       = FETCH;
        end
        JUMP: begin
          bus.PCWrite   = 1'b1;
          bus.PCSource  = 2'd2;
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        JALS: begin
          // Link value is the PC already advanced by FETCH.
          bus.PCWrite   = 1'b1;
          bus.PCSource  = 2'd2;
          bus.RegDst    = 2'd2;
          bus.MemtoReg  = 2'd2;
          bus.RegWrite  = 1'b1;
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        JRS: begin
          bus.PCWrite   = 1'b1;
          bus.PCSource  = 2'd3;
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        NOPS: begin
          bus.InstrDone = 1'b1;
          state_nxt     = FETCH;
        end
        HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          bus.Illegal = 1'b1;
`endif
          state_nxt = HALT;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control word checks across all instruction classes.
// Covers reset masking, memory stalls, MemFault at WAIT_MAX=15, async reset in MEMWR, illegal opcode.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after posedge.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw;
    logic [1:0] regdst, m2r;
    logic       rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [5:0] aluop;
    logic       done, fault, ill;
  } cw_t;

  localparam logic [5:0] A_ADD = 6'b100000;
  localparam logic [5:0] A_SUB = 6'b100010;
  localparam logic [5:0] A_XOR = 6'b100110;
  localparam logic [5:0] A_NOP = 6'b101100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_W(6)) bus ();

  multicycle_control #(.ALUOP_W(6), .WAIT_MAX(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic cw_t sample();
    cw_t s;
    s.pcw = bus.PCWrite;   s.pcwc = bus.PCWriteCond; s.iord = bus.IorD;
    s.mrd = bus.MemRead;   s.mwr = bus.MemWrite;     s.irw = bus.IRWrite;
    s.regdst = bus.RegDst; s.m2r = bus.MemtoReg;     s.rw = bus.RegWrite;
    s.srca = bus.ALUSrcA;  s.srcb = bus.ALUSrcB;     s.pcsrc = bus.PCSource;
    s.aluop = bus.ALUOp;   s.done = bus.InstrDone;   s.fault = bus.MemFault;
`ifdef CTRL_ILLEGAL_TRAP_EN
    s.ill = bus.Illegal;
`else
    s.ill = 1'b0;
`endif
    return s;
  endfunction

  function automatic cw_t idle();
    cw_t e = '0;
    e.aluop = A_NOP;
    return e;
  endfunction

  function automatic cw_t w_fetch(input logic mr, input logic flt);
    cw_t e = idle();
    e.mrd = 1'b1; e.srcb = 2'd1; e.aluop = A_ADD;
    e.irw = mr; e.pcw = mr; e.fault = flt;
    return e;
  endfunction
  function automatic cw_t w_decode();
    cw_t e = idle(); e.srcb = 2'd2; e.aluop = A_ADD; return e;
  endfunction
  function automatic cw_t w_memadr();
    cw_t e = idle(); e.srca = 1'b1; e.srcb = 2'd2; e.aluop = A_ADD; return e;
  endfunction
  function automatic cw_t w_memrd();
    cw_t e = idle(); e.iord = 1'b1; e.mrd = 1'b1; return e;
  endfunction
  function automatic cw_t w_memwb();
    cw_t e = idle(); e.m2r = 2'd1; e.rw = 1'b1; e.done = 1'b1; return e;
  endfunction
  function automatic cw_t w_memwr(input logic mr);
    cw_t e = idle(); e.iord = 1'b1; e.mwr = 1'b1; e.done = mr; return e;
  endfunction
  function automatic cw_t w_rex(input logic [5:0] fn);
    cw_t e = idle(); e.srca = 1'b1; e.aluop = fn; return e;
  endfunction
  function automatic cw_t w_rwb(input logic [5:0] fn);
    cw_t e = idle(); e.regdst = 2'd1; e.rw = 1'b1; e.aluop = fn; e.done = 1'b1; return e;
  endfunction
  function automatic cw_t w_iex();
    cw_t e = idle(); e.srca = 1'b1; e.srcb = 2'd3; e.aluop = A_XOR; return e;
  endfunction
  function automatic cw_t w_iwb();
    cw_t e = idle(); e.rw = 1'b1; e.aluop = A_XOR; e.done = 1'b1; return e;
  endfunction
  function automatic cw_t w_branch();
    cw_t e = idle();
    e.srca = 1'b1; e.aluop = A_SUB; e.pcwc = 1'b1; e.pcsrc = 2'd1; e.done = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_jump();
    cw_t e = idle(); e.pcw = 1'b1; e.pcsrc = 2'd2; e.done = 1'b1; return e;
  endfunction
  function automatic cw_t w_jal();
    cw_t e = idle();
    e.pcw = 1'b1; e.pcsrc = 2'd2; e.regdst = 2'd2; e.m2r = 2'd2; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction
  function automatic cw_t w_jr();
    cw_t e = idle(); e.pcw = 1'b1; e.pcsrc = 2'd3; e.done = 1'b1; return e;
  endfunction
  function automatic cw_t w_nop();
    cw_t e = idle(); e.done = 1'b1; return e;
  endfunction

  task automatic check(input string tag, input cw_t e);
    cw_t o;
    o = sample();
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Check the current cycle, then move to 1 unit after the next posedge.
  task automatic step(input string tag, input cw_t e);
    #1;
    check(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  initial begin
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", idle());
    reset_n = 1'b1;
    #1;
    check("reset_release", idle());
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;

    // ADD: 4 cycles
    set_instr(6'b000000, 6'b100000);
    step("add_fetch", w_fetch(1'b1, 1'b0));
    step("add_decode", w_decode());
    step("add_rex", w_rex(A_ADD));
    step("add_rwb", w_rwb(A_ADD));

    // SUB: R-type ALUOp follows funct
    set_instr(6'b000000, 6'b100010);
    step("sub_fetch", w_fetch(1'b1, 1'b0));
    step("sub_decode", w_decode());
    step("sub_rex", w_rex(A_SUB));
    step("sub_rwb", w_rwb(A_SUB));

    // SLT
    set_instr(6'b000000, 6'b101010);
    step("slt_fetch", w_fetch(1'b1, 1'b0));
    step("slt_decode", w_decode());
    step("slt_rex", w_rex(6'b101010));
    step("slt_rwb", w_rwb(6'b101010));

    // XORI
    set_instr(6'b001110, 6'b010101);
    step("xori_fetch", w_fetch(1'b1, 1'b0));
    step("xori_decode", w_decode());
    step("xori_iex", w_iex());
    step("xori_iwb", w_iwb());

    // LW with three wait cycles in MEMRD: 8 cycles total
    set_instr(6'b100011, 6'b000000);
    step("lw_fetch", w_fetch(1'b1, 1'b0));
    step("lw_decode", w_decode());
    step("lw_memadr", w_memadr());
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", w_memrd());
    bus.mem_ready = 1'b1;
    step("lw_memrd_done", w_memrd());
    step("lw_memwb", w_memwb());

    // SW with one wait cycle in MEMWR
    set_instr(6'b101011, 6'b000000);
    step("sw_fetch", w_fetch(1'b1, 1'b0));
    step("sw_decode", w_decode());
    step("sw_memadr", w_memadr());
    bus.mem_ready = 1'b0;
    step("sw_memwr_wait", w_memwr(1'b0));
    bus.mem_ready = 1'b1;
    step("sw_memwr_done", w_memwr(1'b1));

    // BNE with zero=0 then zero=1: controller output identical
    set_instr(6'b000101, 6'b000000);
    bus.zero = 1'b0;
    step("bne0_fetch", w_fetch(1'b1, 1'b0));
    step("bne0_decode", w_decode());
    step("bne0_branch", w_branch());
    bus.zero = 1'b1;
    step("bne1_fetch", w_fetch(1'b1, 1'b0));
    step("bne1_decode", w_decode());
    step("bne1_branch", w_branch());
    bus.zero = 1'b0;

    // J, JAL, JR, NOOP
    set_instr(6'b000010, 6'b000000);
    step("j_fetch", w_fetch(1'b1, 1'b0));
    step("j_decode", w_decode());
    step("j_jump", w_jump());
    set_instr(6'b000011, 6'b000000);
    step("jal_fetch", w_fetch(1'b1, 1'b0));
    step("jal_decode", w_decode());
    step("jal_jal", w_jal());
    set_instr(6'b000000, 6'b001000);
    step("jr_fetch", w_fetch(1'b1, 1'b0));
    step("jr_decode", w_decode());
    step("jr_jr", w_jr());
    set_instr(6'b000000, 6'b000000);
    step("noop_fetch", w_fetch(1'b1, 1'b0));
    step("noop_decode", w_decode());
    step("noop_nop", w_nop());

    // FETCH stalled 20 cycles: fault on the 16th (counter already at 15)
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) step("fault_wait", w_fetch(1'b0, i == 16));
    bus.mem_ready = 1'b1;
    step("fault_fetch_done", w_fetch(1'b1, 1'b0));
    step("fault_decode", w_decode());
    step("fault_nop", w_nop());

    // Completion on the same cycle the counter hits the limit: no fault
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) step("limit_wait", w_fetch(1'b0, 1'b0));
    bus.mem_ready = 1'b1;
    step("limit_fetch_done", w_fetch(1'b1, 1'b0));
    step("limit_decode", w_decode());
    step("limit_nop", w_nop());

    // Asynchronous reset in MEMWR
    set_instr(6'b101011, 6'b000000);
    step("swr_fetch", w_fetch(1'b1, 1'b0));
    step("swr_decode", w_decode());
    step("swr_memadr", w_memadr());
    bus.mem_ready = 1'b0;
    #1;
    check("swr_memwr_wait", w_memwr(1'b0));
    #1;
    reset_n = 1'b0;
    #1;
    check("swr_reset_async", idle());
    reset_n = 1'b1;
    #1;
    check("swr_reset_release", idle());
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    step("swr_refetch", w_fetch(1'b1, 1'b0));
    step("swr_decode2", w_decode());
    step("swr_memadr2", w_memadr());
    step("swr_memwr2", w_memwr(1'b1));

    // Unsupported opcode
    set_instr(6'b111111, 6'b000000);
    step("ill_fetch", w_fetch(1'b1, 1'b0));
    step("ill_decode", w_decode());
`ifdef CTRL_ILLEGAL_TRAP_EN
    begin
      cw_t h;
      h = idle();
      h.ill = 1'b1;
      for (int i = 0; i < 3; i++) step("ill_halt", h);
      reset_n = 1'b0;
      #1;
      check("ill_reset", idle());
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      set_instr(6'b000000, 6'b000000);
      step("ill_recover_fetch", w_fetch(1'b1, 1'b0));
    end
`else
    step("ill_as_nop", w_nop());
    set_instr(6'b000000, 6'b000000);
    step("ill_next_fetch", w_fetch(1'b1, 1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
